// File: rtl/expr_vector_sequencer.sv
// rtl/expr_vector_sequencer.sv - LFSR operand sequencer with MISR signature compaction
module expr_vector_sequencer #(
    parameter int          SETTLE_CYC = 2,
    parameter int          CNT_W      = 16,
    parameter logic [59:0] LFSR_TAPS  = 60'hC00_0000_0000_0000,
    parameter logic [89:0] MISR_TAPS  = 90'h3C0_0000_0000_0000_0000_0000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [59:0]      seed,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [89:0]      exp_sig,
    output logic [59:0]      opnd,
    input  logic [89:0]      y_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [89:0]      signature,
    output logic [CNT_W-1:0] vec_cnt
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] APPLY   = 3'd1;
    localparam logic [2:0] SETTLE  = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    logic [2:0]       state;
    logic [59:0]      lfsr;
    logic [89:0]      misr;
    logic [89:0]      exp_lat;
    logic [CNT_W-1:0] num_lat;
    logic [SW-1:0]    scnt;
    logic             zero_run;
    logic [CNT_W-1:0] cnt_next;

    assign cnt_next  = vec_cnt + CNT_W'(1);
    assign busy      = (state != IDLE);
    assign signature = misr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            lfsr     <= '0;
            misr     <= '0;
            exp_lat  <= '0;
            num_lat  <= '0;
            scnt     <= '0;
            zero_run <= 1'b0;
            opnd     <= '0;
            vec_cnt  <= '0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Abort overrides everything; opnd, signature and vec_cnt keep their values.
                state <= IDLE;
                pass  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            exp_lat <= exp_sig;
                            pass    <= 1'b0;
                            if (num_vec != '0) begin
                                lfsr     <= (seed == '0) ? 60'd1 : seed;
                                misr     <= '0;
                                vec_cnt  <= '0;
                                num_lat  <= num_vec;
                                zero_run <= 1'b0;
                                state    <= APPLY;
                            end else begin
                                zero_run <= 1'b1;
                                state    <= DONE;
                            end
                        end
                    end
                    APPLY: begin
                        opnd  <= lfsr;
                        scnt  <= '0;
                        state <= SETTLE;
                    end
                    SETTLE: begin
                        if (scnt == SETTLE_LAST) begin
                            state <= CAPTURE;
                        end else begin
                            scnt <= scnt + SW'(1);
                        end
                    end
                    CAPTURE: begin
                        misr    <= {misr[88:0], ^(misr & MISR_TAPS)} ^ y_in;
                        lfsr    <= {lfsr[58:0], ^(lfsr & LFSR_TAPS)};
                        vec_cnt <= cnt_next;
                        state   <= (cnt_next == num_lat) ? DONE : APPLY;
                    end
                    DONE: begin
                        done  <= 1'b1;
                        pass  <= zero_run ? (exp_lat == '0) : (misr == exp_lat);
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
